// File: rtl/id_ex_stage_reg_pkg.sv
// rtl/id_ex_stage_reg_pkg.sv - shared widths, control bundle type and nullify FSM encoding
package id_ex_stage_reg_pkg;

  localparam int unsigned SRD_W   = 2;
  localparam int unsigned PSW_W   = 2;
  localparam int unsigned SOH_W   = 3;
  localparam int unsigned ALU_W   = 4;
  localparam int unsigned RAM_W   = 4;
  localparam int unsigned ID_SR_W = 2;
  localparam int unsigned COND_W  = 3;

  // Control bundle produced by the CU NOP mux; an all-zero value is a bubble.
  typedef struct packed {
    logic [SRD_W-1:0]   srd;
    logic [PSW_W-1:0]   psw_le_re;
    logic [ID_SR_W-1:0] id_sr;
    logic               b;
    logic               l;
    logic               rf_le;
    logic               ub;
    logic               shf;
    logic [SOH_W-1:0]   soh_op;
    logic [ALU_W-1:0]   alu_op;
    logic [RAM_W-1:0]   ram_ctrl;
  } ctrl_bundle_t;

  localparam ctrl_bundle_t BUBBLE = '0;

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } null_state_e;

endpackage

// File: rtl/id_ex_stage_reg_ctrl_bundle_reg.sv
// rtl/id_ex_stage_reg_ctrl_bundle_reg.sv - control bundle register with enable and sync clear
module id_ex_stage_reg_ctrl_bundle_reg
  import id_ex_stage_reg_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         clr,
  input  ctrl_bundle_t d,
  output ctrl_bundle_t q
);

  ctrl_bundle_t bundle_d;
  ctrl_bundle_t bundle_q;

  // Clear wins over enable so a squash can be forced even while stalled.
  always_comb begin
    bundle_d = bundle_q;
    if (clr) begin
      bundle_d = BUBBLE;
    end else if (en) begin
      bundle_d = d;
    end
  end

  // Bundle storage, reset straight to a bubble.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bundle_q <= BUBBLE;
    end else begin
      bundle_q <= bundle_d;
    end
  end

  assign q = bundle_q;

endmodule

// File: rtl/id_ex_stage_reg.sv
// rtl/id_ex_stage_reg.sv - ID/EX pipeline register with flush bubbles and held nullify
module id_ex_stage_reg
  import id_ex_stage_reg_pkg::*;
#(
  parameter int unsigned DW = 32,
  parameter int unsigned RW = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               LE,
  input  logic               flush,
  input  logic               nullify_req,
  input  logic               id_valid,
  input  logic [SRD_W-1:0]   SRD_in,
  input  logic [PSW_W-1:0]   PSW_LE_RE_in,
  input  logic [ID_SR_W-1:0] ID_SR_in,
  input  logic               B_in,
  input  logic               L_in,
  input  logic               RF_LE_in,
  input  logic               UB_in,
  input  logic               SHF_in,
  input  logic [SOH_W-1:0]   SOH_OP_in,
  input  logic [ALU_W-1:0]   ALU_OP_in,
  input  logic [RAM_W-1:0]   RAM_CTRL_in,
  input  logic [COND_W-1:0]  COND_in,
  input  logic [DW-1:0]      PC_in,
  input  logic [DW-1:0]      RA_in,
  input  logic [DW-1:0]      RB_in,
  input  logic [DW-1:0]      IMM_in,
  input  logic [RW-1:0]      RD_in,
  output logic [SRD_W-1:0]   SRD_out,
  output logic [PSW_W-1:0]   PSW_LE_RE_out,
  output logic [ID_SR_W-1:0] ID_SR_out,
  output logic               B_out,
  output logic               L_out,
  output logic               RF_LE_out,
  output logic               UB_out,
  output logic               SHF_out,
  output logic [SOH_W-1:0]   SOH_OP_out,
  output logic [ALU_W-1:0]   ALU_OP_out,
  output logic [RAM_W-1:0]   RAM_CTRL_out,
  output logic [COND_W-1:0]  COND_out,
  output logic [DW-1:0]      PC_out,
  output logic [DW-1:0]      RA_out,
  output logic [DW-1:0]      RB_out,
  output logic [DW-1:0]      IMM_out,
  output logic [RW-1:0]      RD_out,
  output logic               ex_valid,
  output logic               nullify_pending
);

  null_state_e state_d, state_q;
  logic        nullify_eff;
  logic        ctrl_clr;
  ctrl_bundle_t ctrl_in, ctrl_q;

  logic [COND_W-1:0] cond_d, cond_q;
  logic [DW-1:0]     pc_d, pc_q, ra_d, ra_q, rb_d, rb_q, imm_d, imm_q;
  logic [RW-1:0]     rd_d, rd_q;
  logic              ex_valid_d, ex_valid_q;

  // A squash request applies to this load whether it arrives now or was parked during a stall.
  assign nullify_eff = nullify_req | (state_q == PEND);
  assign ctrl_clr    = flush | (LE & nullify_eff);

  assign ctrl_in = '{
    srd:       SRD_in,
    psw_le_re: PSW_LE_RE_in,
    id_sr:     ID_SR_in,
    b:         B_in,
    l:         L_in,
    rf_le:     RF_LE_in,
    ub:        UB_in,
    shf:       SHF_in,
    soh_op:    SOH_OP_in,
    alu_op:    ALU_OP_in,
    ram_ctrl:  RAM_CTRL_in
  };

  id_ex_stage_reg_ctrl_bundle_reg u_ctrl_reg (
    .clk   (clk),
    .reset (reset),
    .en    (LE),
    .clr   (ctrl_clr),
    .d     (ctrl_in),
    .q     (ctrl_q)
  );

  // Nullify FSM: park a request raised during a stall; any load or a flush retires it.
  always_comb begin
    state_d = state_q;
    if (flush || LE) begin
      state_d = IDLE;
    end else if (nullify_req) begin
      state_d = PEND;
    end
  end

  // Operand, condition and valid next-state; a nullified slot keeps operands but no control.
  always_comb begin
    cond_d     = cond_q;
    pc_d       = pc_q;
    ra_d       = ra_q;
    rb_d       = rb_q;
    imm_d      = imm_q;
    rd_d       = rd_q;
    ex_valid_d = ex_valid_q;
    if (flush) begin
      cond_d     = '0;
      pc_d       = '0;
      ra_d       = '0;
      rb_d       = '0;
      imm_d      = '0;
      rd_d       = '0;
      ex_valid_d = 1'b0;
    end else if (LE) begin
      pc_d  = PC_in;
      ra_d  = RA_in;
      rb_d  = RB_in;
      imm_d = IMM_in;
      rd_d  = RD_in;
      if (nullify_eff) begin
        cond_d     = '0;
        ex_valid_d = 1'b0;
      end else begin
        cond_d     = COND_in;
        ex_valid_d = id_valid;
      end
    end
  end

  // State and data registers, all cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cond_q     <= '0;
      pc_q       <= '0;
      ra_q       <= '0;
      rb_q       <= '0;
      imm_q      <= '0;
      rd_q       <= '0;
      ex_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cond_q     <= cond_d;
      pc_q       <= pc_d;
      ra_q       <= ra_d;
      rb_q       <= rb_d;
      imm_q      <= imm_d;
      rd_q       <= rd_d;
      ex_valid_q <= ex_valid_d;
    end
  end

  assign SRD_out         = ctrl_q.srd;
  assign PSW_LE_RE_out   = ctrl_q.psw_le_re;
  assign ID_SR_out       = ctrl_q.id_sr;
  assign B_out           = ctrl_q.b;
  assign L_out           = ctrl_q.l;
  assign RF_LE_out       = ctrl_q.rf_le;
  assign UB_out          = ctrl_q.ub;
  assign SHF_out         = ctrl_q.shf;
  assign SOH_OP_out      = ctrl_q.soh_op;
  assign ALU_OP_out      = ctrl_q.alu_op;
  assign RAM_CTRL_out    = ctrl_q.ram_ctrl;
  assign COND_out        = cond_q;
  assign PC_out          = pc_q;
  assign RA_out          = ra_q;
  assign RB_out          = rb_q;
  assign IMM_out         = imm_q;
  assign RD_out          = rd_q;
  assign ex_valid        = ex_valid_q;
  assign nullify_pending = (state_q == PEND);

endmodule
